// File: rtl/uncache_agent_pkg.sv
// Shared definitions for the uncached AXI agent: FSM state encoding and the
// fixed single-beat AXI burst parameters.
package uncache_agent_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } uncache_state_t;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/uncache_agent.sv
// Single-outstanding uncached access agent: turns one upstream request into
// one AXI single-beat read or write and reports completion via data_ok.
module uncache_agent
  import uncache_agent_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] axi_rdata,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready
);

  uncache_state_t r_state;
  uncache_state_t w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;

  logic w_accept;
  logic w_aw_fire;
  logic w_w_fire;

  assign w_accept  = req && (r_state == IDLE);
  assign w_aw_fire = (r_state == WR_REQ) && !r_aw_done && awready;
  assign w_w_fire  = (r_state == WR_REQ) && !r_w_done  && wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Payload carries no reset: it is only observed after a fresh accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_size  <= size;
      r_wstrb <= wstrb;
      r_wdata <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state != WR_REQ) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    data_ok = 1'b0;
    rdata   = '0;
    case (r_state)
      IDLE: begin
        if (req) w_next = we ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_ok = 1'b1;
          rdata   = axi_rdata;
          w_next  = IDLE;
        end
      end
      WR_REQ: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        // A handshake landing this cycle counts as done, so both orders and
        // the same-cycle case all leave after the later of the two.
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_ok = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign addr_ok   = w_accept;
  assign araddr    = r_addr;
  assign awaddr    = r_addr;
  assign arsize    = axi_size(r_size);
  assign awsize    = axi_size(r_size);
  assign axi_wdata = r_wdata;
  assign axi_wstrb = r_wstrb;
  assign wlast     = 1'b1;

endmodule

// File: doc/uncache_agent.md
UNCACHE_AGENT -- requirements
Module: uncache_agent

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset as elsewhere in the codebase.
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 req / we / size / wstrb / addr / wdata  in  1/1/2/4/32/32  translated upstream request; size 0=byte, 1=half, 2=word.
REQ-005 addr_ok  out  1  request accepted this cycle.
REQ-006 data_ok  out  1  one-cycle pulse: read data valid or write acknowledged.
REQ-007 rdata  out  32  load data, valid only while data_ok is high.
REQ-008 arvalid/arready/araddr/arsize  out/in/out/out  1/1/32/3  AXI read-address channel (len 0, burst INCR).
REQ-009 rvalid/rready/axi_rdata  in/out/in  1/1/32  AXI read-data channel; rresp ignored.
REQ-010 awvalid/awready/awaddr/awsize  out/in/out/out  1/1/32/3  AXI write-address channel.
REQ-011 wvalid/wready/axi_wdata/axi_wstrb/wlast  out/in/out/out/out  1/1/32/4/1  AXI write-data channel; wlast tied to 1.
REQ-012 bvalid/bready  in/out  1/1  AXI write-response channel; bresp ignored.

Function
REQ-013 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_REQ, and WR_RESP, with at most one transaction outstanding.
REQ-014 addr_ok SHALL be combinationally equal to req && state==IDLE.
REQ-015 On addr_ok, addr, size, wstrb, and wdata SHALL be registered, and the FSM SHALL move to RD_ADDR when we=0 or to WR_REQ when we=1.
REQ-016 arsize/awsize SHALL be {1'b0,size}; the address SHALL be forwarded unaligned-unmodified, and the registered wstrb/wdata SHALL drive the W channel unchanged.
REQ-017 RD_ADDR SHALL drive arvalid=1 and go to RD_DATA on arvalid&&arready.
REQ-018 RD_DATA SHALL drive rready=1; on rvalid it SHALL pulse data_ok, set rdata=axi_rdata the same cycle, and return to IDLE.
REQ-019 WR_REQ SHALL drive awvalid and wvalid independently, using the flags aw_done and w_done; each valid SHALL drop after its own handshake.
REQ-020 The AW and W handshakes SHALL complete in either order or in the same cycle, and the FSM SHALL go to WR_RESP once both are done.
REQ-021 WR_RESP SHALL drive bready=1; on bvalid it SHALL pulse data_ok and return to IDLE.
REQ-022 Minimum latency SHALL be: accept at cycle T, arvalid at T+1, data_ok at T+2 when arready and rvalid arrive immediately.
REQ-023 A req presented in the cycle data_ok pulses SHALL NOT be accepted; it SHALL be accepted in the next cycle (IDLE).
REQ-024 Once asserted, an AXI valid SHALL stay asserted with stable payload until its handshake.
REQ-025 Upstream request inputs SHALL be ignored outside IDLE.
REQ-026 rvalid/bvalid arriving in an unexpected state SHALL be ignored, with rready/bready held low.

Reset
REQ-027 Reset SHALL force the state to IDLE and clear aw_done/w_done.
REQ-028 Reset SHALL drive arvalid/awvalid/wvalid/rready/bready/data_ok to 0 immediately, with no clock edge needed.
REQ-029 Reset mid-transaction SHALL abandon the transaction without producing data_ok.
REQ-030 Registered payload values SHALL be don't-care after reset.

Structure
REQ-031 uncache_state_t SHALL reside in the shared definitions package.
REQ-032 The AXI burst/len constants SHALL reside in the shared definitions package.
REQ-033 The block SHALL be a single module; no sub-module is required.

Verification
REQ-034 Read: req=1, we=0, addr=0x1FD0_0004, size=2, with arready and rvalid immediate and axi_rdata=0xDEADBEEF -> addr_ok at T, araddr=0x1FD0_0004 and arsize=2 at T+1, data_ok with rdata=0xDEADBEEF at T+2.
REQ-035 Write: addr=0x1FD0_0001, size=0, wstrb=0010, wdata=0x55555555, wready 3 cycles before awready -> wvalid drops after its handshake while awvalid stays, then bready, then a single data_ok.
REQ-036 Simultaneous AW/W handshake in one cycle -> WR_RESP next cycle and one data_ok on bvalid.
REQ-037 Back-to-back: second req held high during the first data_ok -> second addr_ok exactly one cycle after the first data_ok.
REQ-038 arready held low 5 cycles -> arvalid and araddr stable throughout, and no data_ok.
REQ-039 Reset asserted in RD_DATA, then rvalid after release -> rready=0, no data_ok, IDLE accepts the next req.
